// File: rtl/add_num_pkg.sv
// add_num_pkg: register map, bit positions and FSM state type for the add-numbers AFU CSR block
//   REG_*      word offsets of the 64-bit MMIO registers
//   CTRL_*     bit positions inside the CTRL write
//   ST_*       bit positions inside STATUS
//   DFH_VALUE  device feature header contents
package add_num_pkg;
  localparam int unsigned REG_DFH        = 'h00;
  localparam int unsigned REG_ID_L       = 'h02;
  localparam int unsigned REG_ID_H       = 'h04;
  localparam int unsigned REG_SRC_ADDR   = 'h10;
  localparam int unsigned REG_DST_ADDR   = 'h12;
  localparam int unsigned REG_CTRL       = 'h14;
  localparam int unsigned REG_STATUS     = 'h16;
  localparam int unsigned REG_RESULT     = 'h18;
  localparam int unsigned REG_DONE_COUNT = 'h1A;
  localparam int unsigned CTRL_START     = 0;
  localparam int unsigned CTRL_CLR_ERR   = 1;
  localparam int unsigned ST_BUSY        = 0;
  localparam int unsigned ST_DONE        = 1;
  localparam int unsigned ST_ERR         = 2;
  localparam logic [63:0] DFH_VALUE      = 64'h1000_0100_0000_0000;
  typedef enum logic {IDLE, BUSY} t_csr_state;
endpackage

// File: rtl/add_num_csr.sv
// add_num_csr: MMIO CSR block that configures, launches and tracks the add engine
//   clk, reset_n                      clock, asynchronous active-low reset
//   mmio_rd_valid/wr_valid/addr/tid   CCI-P MMIO request (at most one of rd/wr per cycle)
//   mmio_wr_data                      write payload
//   mmio_rd_rsp_valid/tid/data        read response, one cycle after the request
//   src_addr, dst_addr                operand and result line addresses for the engine
//   start                             one-cycle engine launch pulse
//   engine_done, engine_result        completion pulse and result from the engine
module add_num_csr
  import add_num_pkg::*;
#(
  parameter logic [127:0] AFU_ID      = 128'h0,
  parameter int unsigned  MMIO_ADDR_W = 16,
  parameter int unsigned  TID_W       = 9,
  parameter int unsigned  CL_ADDR_W   = 42
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mmio_rd_valid,
  input  logic                   mmio_wr_valid,
  input  logic [MMIO_ADDR_W-1:0] mmio_addr,
  input  logic [TID_W-1:0]       mmio_tid,
  input  logic [63:0]            mmio_wr_data,
  output logic                   mmio_rd_rsp_valid,
  output logic [TID_W-1:0]       mmio_rd_rsp_tid,
  output logic [63:0]            mmio_rd_rsp_data,
  output logic [CL_ADDR_W-1:0]   src_addr,
  output logic [CL_ADDR_W-1:0]   dst_addr,
  output logic                   start,
  input  logic                   engine_done,
  input  logic [63:0]            engine_result
);
  t_csr_state  state, state_nxt;
  logic        done, err, err_nxt;
  logic [63:0] result, rd_data;
  logic [31:0] done_count;
  logic        wr_src, wr_dst, wr_ctrl, req_start, req_clr, done_ev, accept, busy;
  logic        unused_wr_bits;
  assign unused_wr_bits = ^mmio_wr_data[63:CL_ADDR_W];
  always_comb begin
    busy      = state == BUSY;
    wr_src    = mmio_wr_valid && mmio_addr == MMIO_ADDR_W'(REG_SRC_ADDR);
    wr_dst    = mmio_wr_valid && mmio_addr == MMIO_ADDR_W'(REG_DST_ADDR);
    wr_ctrl   = mmio_wr_valid && mmio_addr == MMIO_ADDR_W'(REG_CTRL);
    req_start = wr_ctrl && mmio_wr_data[CTRL_START];
    req_clr   = wr_ctrl && mmio_wr_data[CTRL_CLR_ERR];
    done_ev   = busy && engine_done;
    // a completion arriving with a start write frees the engine in the same cycle, so the start is taken
    accept    = req_start && (!busy || done_ev);
    state_nxt = accept ? BUSY : done_ev ? IDLE : state;
    // clear_err acts before the start is judged, so a rejected start in the same write re-raises err
    err_nxt   = (req_clr ? 1'b0 : err) | (busy && (wr_src || wr_dst || (req_start && !done_ev)));
  end
  always_comb begin
    rd_data = 64'h0;
    case (mmio_addr)
      MMIO_ADDR_W'(REG_DFH):        rd_data = DFH_VALUE;
      MMIO_ADDR_W'(REG_ID_L):       rd_data = AFU_ID[63:0];
      MMIO_ADDR_W'(REG_ID_H):       rd_data = AFU_ID[127:64];
      MMIO_ADDR_W'(REG_SRC_ADDR):   rd_data = 64'(src_addr);
      MMIO_ADDR_W'(REG_DST_ADDR):   rd_data = 64'(dst_addr);
      MMIO_ADDR_W'(REG_STATUS):     rd_data = 64'({err, done, busy});
      MMIO_ADDR_W'(REG_RESULT):     rd_data = result;
      MMIO_ADDR_W'(REG_DONE_COUNT): rd_data = 64'(done_count);
      default:                      rd_data = 64'h0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state             <= IDLE;
      start             <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      src_addr          <= '0;
      dst_addr          <= '0;
      result            <= 64'h0;
      done_count        <= 32'h0;
      mmio_rd_rsp_valid <= 1'b0;
      mmio_rd_rsp_tid   <= '0;
      mmio_rd_rsp_data  <= 64'h0;
    end else begin
      state             <= state_nxt;
      start             <= accept;
      err               <= err_nxt;
      done              <= accept ? 1'b0 : done_ev ? 1'b1 : done;
      if (wr_src && !busy) src_addr <= mmio_wr_data[CL_ADDR_W-1:0];
      if (wr_dst && !busy) dst_addr <= mmio_wr_data[CL_ADDR_W-1:0];
      if (done_ev) begin
        result     <= engine_result;
        done_count <= done_count + 32'd1;
      end
      mmio_rd_rsp_valid <= mmio_rd_valid;
      mmio_rd_rsp_tid   <= mmio_tid;
      mmio_rd_rsp_data  <= rd_data;
    end
endmodule

// File: tb/tb_add_num_csr.sv
// tb_add_num_csr: table-driven, directed and randomized checks of add_num_csr
module tb_add_num_csr;
  localparam logic [127:0] AID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mmio_rd_valid = 1'b0, mmio_wr_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wr_data = '0;
  logic        mmio_rd_rsp_valid;
  logic [8:0]  mmio_rd_rsp_tid;
  logic [63:0] mmio_rd_rsp_data;
  logic [41:0] src_addr, dst_addr;
  logic        start;
  logic        engine_done = 1'b0;
  logic [63:0] engine_result = '0;
  int errors = 0, checks = 0;

  add_num_csr #(.AFU_ID(AID), .MMIO_ADDR_W(16), .TID_W(9), .CL_ADDR_W(42)) dut (
    .clk(clk), .reset_n(reset_n),
    .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_rsp_valid(mmio_rd_rsp_valid), .mmio_rd_rsp_tid(mmio_rd_rsp_tid),
    .mmio_rd_rsp_data(mmio_rd_rsp_data),
    .src_addr(src_addr), .dst_addr(dst_addr), .start(start),
    .engine_done(engine_done), .engine_result(engine_result));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_valid = 1'b1;
    mmio_addr = a;
    mmio_wr_data = d;
    step();
    mmio_wr_valid = 1'b0;
  endtask

  task automatic rd(input string n, input logic [15:0] a, input logic [63:0] e);
    mmio_rd_valid = 1'b1;
    mmio_addr = a;
    mmio_tid = 9'h155;
    step();
    mmio_rd_valid = 1'b0;
    chk({n, "_valid"}, 64'(mmio_rd_rsp_valid), 64'd1);
    chk({n, "_tid"}, 64'(mmio_rd_rsp_tid), 64'h155);
    chk(n, mmio_rd_rsp_data, e);
  endtask

  task automatic done_pulse(input logic [63:0] r);
    engine_done = 1'b1;
    engine_result = r;
    step();
    engine_done = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [8:0]  tid;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[10];

  // reference model state, in register-map terms
  logic        m_busy, m_done, m_err, m_start;
  logic [41:0] m_src, m_dst;
  logic [63:0] m_result;
  logic [31:0] m_count;

  function automatic logic [63:0] model_read(input logic [15:0] a);
    case (a)
      16'h00:  return 64'h1000_0100_0000_0000;
      16'h02:  return AID[63:0];
      16'h04:  return AID[127:64];
      16'h10:  return {22'h0, m_src};
      16'h12:  return {22'h0, m_dst};
      16'h16:  return {61'h0, m_err, m_done, m_busy};
      16'h18:  return m_result;
      16'h1A:  return {32'h0, m_count};
      default: return 64'h0;
    endcase
  endfunction

  task automatic model_cycle(input logic w, input logic [15:0] a, input logic [63:0] d,
                             input logic eng, input logic [63:0] res);
    logic was_busy, fin;
    was_busy = m_busy;
    fin = eng && was_busy;
    m_start = 1'b0;
    if (fin) begin
      m_result = res;
      m_count = m_count + 1;
      m_done = 1'b1;
      m_busy = 1'b0;
    end
    if (w && (a == 16'h10 || a == 16'h12)) begin
      if (was_busy) m_err = 1'b1;
      else if (a == 16'h10) m_src = d[41:0];
      else m_dst = d[41:0];
    end
    if (w && a == 16'h14) begin
      if (d[1]) m_err = 1'b0;
      if (d[0]) begin
        if (was_busy && !fin) m_err = 1'b1;
        else begin
          m_busy = 1'b1;
          m_done = 1'b0;
          m_start = 1'b1;
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{16'h00, 9'h11, 64'h1000_0100_0000_0000};
    tbl[1] = '{16'h02, 9'h12, AID[63:0]};
    tbl[2] = '{16'h04, 9'h13, AID[127:64]};
    tbl[3] = '{16'h06, 9'h14, 64'h0};
    tbl[4] = '{16'h08, 9'h15, 64'h0};
    tbl[5] = '{16'h10, 9'h16, 64'h0};
    tbl[6] = '{16'h14, 9'h17, 64'h0};
    tbl[7] = '{16'h16, 9'h18, 64'h0};
    tbl[8] = '{16'h1A, 9'h19, 64'h0};
    tbl[9] = '{16'h3F, 9'h1FF, 64'h0};

    repeat (3) step();
    chk("reset_rsp_valid", 64'(mmio_rd_rsp_valid), 64'd0);
    chk("reset_start", 64'(start), 64'd0);
    chk("reset_src", 64'(src_addr), 64'd0);
    chk("reset_dst", 64'(dst_addr), 64'd0);
    reset_n = 1'b1;
    step();

    // back-to-back reads straight out of the table
    for (int i = 0; i < 10; i++) begin
      mmio_rd_valid = 1'b1;
      mmio_addr = tbl[i].addr;
      mmio_tid = tbl[i].tid;
      step();
      chk($sformatf("tbl%0d_valid", i), 64'(mmio_rd_rsp_valid), 64'd1);
      chk($sformatf("tbl%0d_tid", i), 64'(mmio_rd_rsp_tid), 64'(tbl[i].tid));
      chk($sformatf("tbl%0d_data", i), mmio_rd_rsp_data, tbl[i].exp);
    end
    mmio_rd_valid = 1'b0;
    step();
    chk("rsp_valid_drop", 64'(mmio_rd_rsp_valid), 64'd0);

    wr(16'h10, 64'h100);
    wr(16'h12, 64'h200);
    wr(16'h14, 64'h1);
    chk("start_pulse", 64'(start), 64'd1);
    step();
    chk("start_one_cycle", 64'(start), 64'd0);
    rd("status_busy", 16'h16, 64'h1);
    chk("src_out", 64'(src_addr), 64'h100);
    chk("dst_out", 64'(dst_addr), 64'h200);

    wr(16'h12, 64'h300);
    chk("dst_frozen", 64'(dst_addr), 64'h200);
    wr(16'h14, 64'h1);
    chk("no_start_busy", 64'(start), 64'd0);
    rd("status_err", 16'h16, 64'h5);
    rd("dst_readback", 16'h12, 64'h200);
    wr(16'h14, 64'h2);
    rd("status_clr", 16'h16, 64'h1);

    done_pulse(64'h32);
    rd("result", 16'h18, 64'h32);
    rd("status_done", 16'h16, 64'h2);
    rd("count1", 16'h1A, 64'h1);
    done_pulse(64'h99);
    rd("result_idle_done", 16'h18, 64'h32);
    rd("status_idle_done", 16'h16, 64'h2);
    rd("count_idle_done", 16'h1A, 64'h1);

    wr(16'h14, 64'h1);
    chk("start2", 64'(start), 64'd1);
    engine_done = 1'b1;
    engine_result = 64'h77;
    wr(16'h14, 64'h1);
    engine_done = 1'b0;
    chk("start_with_done", 64'(start), 64'd1);
    rd("count2", 16'h1A, 64'h2);
    rd("result2", 16'h18, 64'h77);
    rd("status_restart", 16'h16, 64'h1);

    force dut.done_count = 32'hFFFF_FFFF;
    #1 release dut.done_count;
    done_pulse(64'h5);
    rd("count_wrap", 16'h1A, 64'h0);

    wr(16'h14, 64'h1);
    rd("status_pre_reset", 16'h16, 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rsp_valid", 64'(mmio_rd_rsp_valid), 64'd0);
    chk("async_start", 64'(start), 64'd0);
    chk("async_src", 64'(src_addr), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    rd("status_after_reset", 16'h16, 64'h0);
    done_pulse(64'hAB);
    rd("result_after_reset", 16'h18, 64'h0);
    rd("count_after_reset", 16'h1A, 64'h0);

    // randomized traffic against the model; DUT was just reset so the model starts empty
    m_busy = 0; m_done = 0; m_err = 0; m_start = 0;
    m_src = '0; m_dst = '0; m_result = '0; m_count = '0;
    for (int n = 0; n < 3000; n++) begin
      int op;
      logic r, w, eng;
      logic [15:0] a;
      logic [63:0] d, res, exp_rd;
      logic [8:0] t;
      op = int'($urandom_range(0, 5));
      eng = ($urandom_range(0, 3) == 0);
      res = {$urandom, $urandom};
      d = {$urandom, $urandom};
      t = 9'($urandom);
      r = (op == 1 || op == 2);
      w = (op >= 3);
      case ($urandom_range(0, 11))
        0: a = 16'h00;  1: a = 16'h02;  2: a = 16'h04;  3: a = 16'h10;
        4: a = 16'h12;  5: a = 16'h14;  6: a = 16'h16;  7: a = 16'h18;
        8: a = 16'h1A;  9: a = 16'h14;  10: a = 16'h14;
        default: a = 16'($urandom);
      endcase
      if (op == 3) a = 16'h14;
      exp_rd = model_read(a);
      model_cycle(w, a, d, eng, res);
      mmio_rd_valid = r;
      mmio_wr_valid = w;
      mmio_addr = a;
      mmio_tid = t;
      mmio_wr_data = d;
      engine_done = eng;
      engine_result = res;
      step();
      mmio_rd_valid = 1'b0;
      mmio_wr_valid = 1'b0;
      engine_done = 1'b0;
      chk("rnd_start", 64'(start), 64'(m_start));
      chk("rnd_src", 64'(src_addr), 64'(m_src));
      chk("rnd_dst", 64'(dst_addr), 64'(m_dst));
      chk("rnd_rsp_valid", 64'(mmio_rd_rsp_valid), 64'(r));
      if (r) begin
        chk("rnd_tid", 64'(mmio_rd_rsp_tid), 64'(t));
        chk($sformatf("rnd_rd_%h", a), mmio_rd_rsp_data, exp_rd);
      end
    end
    rd("final_status", 16'h16, {61'h0, m_err, m_done, m_busy});
    rd("final_count", 16'h1A, {32'h0, m_count});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
